// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bundle for serial_subtractor
// Optional feature macro: SERIAL_ADD_MODE_EN (adds the mode signal)
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADD_MODE_EN
  logic             mode;
`endif

  // Requester side: drives the operation, observes result and status
  modport master (
    output start, a, b,
`ifdef SERIAL_ADD_MODE_EN
    output mode,
`endif
    input  diff, borrow_out, busy, done
  );

  // Arithmetic unit side
  modport slave (
    input  start, a, b,
`ifdef SERIAL_ADD_MODE_EN
    input  mode,
`endif
    output diff, borrow_out, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor (A - B), LSB first, with start/busy/done
// Optional feature macro: SERIAL_ADD_MODE_EN (mode=1 selects addition, borrow_out carries carry-out)
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_MODE_EN
  logic             mode_q, mode_d;
`endif

  // The single reused cell: sum/difference bit and the next borrow (or carry)
  logic ai, bi, bin, d_bit, bout;
  always_comb begin
    ai    = a_q[0];
    bi    = b_q[0];
    bin   = borrow_q;
    d_bit = ai ^ bi ^ bin;
`ifdef SERIAL_ADD_MODE_EN
    if (mode_q) begin
      bout = (ai & bi) | ((ai ^ bi) & bin);
    end else begin
      bout = (~ai & bi) | (~(ai ^ bi) & bin);
    end
`else
    bout = (~ai & bi) | (~(ai ^ bi) & bin);
`endif
  end

  // Next-state and datapath update: accept in IDLE/DONE, one bit per SHIFT cycle
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    cnt_d        = cnt_q;
`ifdef SERIAL_ADD_MODE_EN
    mode_d       = mode_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          diff_d   = '0;
`ifdef SERIAL_ADD_MODE_EN
          mode_d   = bus.mode;
`endif
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        // start is deliberately not looked at here: operands and count are frozen
        diff_d   = {d_bit, diff_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          borrow_out_d = bout;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt_q        <= '0;
`ifdef SERIAL_ADD_MODE_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      cnt_q        <= cnt_d;
`ifdef SERIAL_ADD_MODE_EN
      mode_q       <= mode_d;
`endif
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH=4)
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One operation: start for one cycle, optionally poke start with other operands in SHIFT cycle 2
  task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input int exp_d, input int exp_b, input bit poke);
    int cyc;
    int busy_cnt;
    bit seen;
    cyc = 0;
    busy_cnt = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!seen && cyc < 20) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (poke && cyc == 2) begin
          bus.a = 4'd1;
          bus.b = 4'd1;
          bus.start = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    check({tag, " done_seen"}, int'(seen), 1);
    check({tag, " latency"}, cyc, 5);
    check({tag, " busy_cycles"}, busy_cnt, 4);
    check({tag, " diff"}, int'(bus.diff), exp_d);
    check({tag, " borrow_out"}, int'(bus.borrow_out), exp_b);
    @(negedge clk);
    check({tag, " done_pulse_width"}, int'(bus.done), 0);
    check({tag, " diff_hold"}, int'(bus.diff), exp_d);
  endtask

  initial begin
    int cnt;
    int done_cnt;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef SERIAL_ADD_MODE_EN
    bus.mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset diff", int'(bus.diff), 0);
    check("reset borrow_out", int'(bus.borrow_out), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    rst_n = 1'b1;

    run_op("9-5", 4'd9, 4'd5, 4, 0, 1'b0);
    run_op("5-9", 4'd5, 4'd9, 12, 1, 1'b0);
    run_op("0-15", 4'd0, 4'd15, 1, 1, 1'b0);
    run_op("15-15", 4'd15, 4'd15, 0, 0, 1'b0);
    run_op("10-3", 4'd10, 4'd3, 7, 0, 1'b0);
    run_op("ignored_start", 4'd9, 4'd5, 4, 0, 1'b1);

    // Leave borrow_out=1 behind, then abort a new operation in SHIFT cycle 2
    run_op("6-8", 4'd6, 4'd8, 14, 1, 1'b0);
    @(negedge clk);
    bus.a = 4'd9;
    bus.b = 4'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort diff", int'(bus.diff), 0);
    check("abort borrow_out", int'(bus.borrow_out), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    check("abort no_done", done_cnt, 0);
    rst_n = 1'b1;
    run_op("3-1_after_abort", 4'd3, 4'd1, 2, 0, 1'b0);

    // Start held high: one result every WIDTH+1 cycles
    @(negedge clk);
    bus.a = 4'd9;
    bus.b = 4'd5;
    bus.start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.done && cnt < 20);
    check("b2b first_done", int'(bus.done), 1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.done && cnt < 20);
    check("b2b interval", cnt, 5);
    check("b2b diff", int'(bus.diff), 4);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b idle_after", int'(bus.busy), 0);

`ifdef SERIAL_ADD_MODE_EN
    bus.mode = 1'b1;
    run_op("add 7+9", 4'd7, 4'd9, 0, 1, 1'b0);
    run_op("add 3+4", 4'd3, 4'd4, 7, 0, 1'b0);
    bus.mode = 1'b0;
    run_op("sub_after_add 9-5", 4'd9, 4'd5, 4, 0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
